hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl_fwd_select.sv | 25 ++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states,
// forwarding selects and internal counter widths.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        MEM_WAIT  = 2'd2
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Sized for the widest legal LOAD_DELAY (4) and MD_LATENCY (64).
    localparam int unsigned LD_CNT_W = 3;
    localparam int unsigned MD_CNT_W = 7;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle; the slave side is the hazard controller.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 5
);
    logic             ctrlMemRead_ID_EX;
    logic [REG_W-1:0] rt_ID_EX;
    logic [REG_W-1:0] rs_IF_ID;
    logic [REG_W-1:0] rt_IF_ID;
    logic             usesRs_IF_ID;
    logic             usesRt_IF_ID;
    logic             usesHiLo_IF_ID;
    logic             mdStart;
    logic [REG_W-1:0] rs_ID_EX;
    logic             regWrite_EX_MEM;
    logic             regWrite_MEM_WB;
    logic [REG_W-1:0] rd_EX_MEM;
    logic [REG_W-1:0] rd_MEM_WB;
    logic             branchTaken_ID;
    logic             memReady;

    logic             stallPC;
    logic             stallIF_ID;
    logic             flushIF_ID;
    logic             flushID_EX;
    logic             freezeAll;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;
    logic             mdBusy;

    modport master (
        output ctrlMemRead_ID_EX, rt_ID_EX, rs_IF_ID, rt_IF_ID, usesRs_IF_ID,
               usesRt_IF_ID, usesHiLo_IF_ID, mdStart, rs_ID_EX, regWrite_EX_MEM,
               regWrite_MEM_WB, rd_EX_MEM, rd_MEM_WB, branchTaken_ID, memReady,
        input  stallPC, stallIF_ID, flushIF_ID, flushID_EX, freezeAll,
               fwdA, fwdB, mdBusy
    );

    modport slave (
        input  ctrlMemRead_ID_EX, rt_ID_EX, rs_IF_ID, rt_IF_ID, usesRs_IF_ID,
               usesRt_IF_ID, usesHiLo_IF_ID, mdStart, rs_ID_EX, regWrite_EX_MEM,
               regWrite_MEM_WB, rd_EX_MEM, rd_MEM_WB, branchTaken_ID, memReady,
        output stallPC, stallIF_ID, flushIF_ID, flushID_EX, freezeAll,
               fwdA, fwdB, mdBusy
    );

endinterface

// File: rtl/hazard_ctrl_fwd_select.sv
// Operand forwarding select for one EX source register; EX/MEM beats MEM/WB.
module fwd_select
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] src,
    input  logic         we_mem,
    input  logic [W-1:0] rd_mem,
    input  logic         we_wb,
    input  logic [W-1:0] rd_wb,
    output fwd_sel_e     sel
);

    always_comb begin
        sel = FWD_REG;
        if (we_wb && (rd_wb != '0) && (rd_wb == src)) begin
            sel = FWD_WB;
        end
        if (we_mem && (rd_mem != '0) && (rd_mem == src)) begin
            sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use and HI/LO stalls, memory freeze,
// branch flush and EX operand forwarding selects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned LOAD_DELAY = 1,
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    hz_state_e             state_q, state_d;
    hz_state_e             ret_q, ret_d;
    hz_state_e             eff_state;
    logic [LD_CNT_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;
    logic                  load_use;
    logic                  hilo_haz;
    logic                  stall;
    logic                  freeze;
    fwd_sel_e              fwd_a, fwd_b;

    fwd_select #(.W(REG_W)) u_fwd_a (
        .src    (hz.rs_ID_EX),
        .we_mem (hz.regWrite_EX_MEM),
        .rd_mem (hz.rd_EX_MEM),
        .we_wb  (hz.regWrite_MEM_WB),
        .rd_wb  (hz.rd_MEM_WB),
        .sel    (fwd_a)
    );

    fwd_select #(.W(REG_W)) u_fwd_b (
        .src    (hz.rt_ID_EX),
        .we_mem (hz.regWrite_EX_MEM),
        .rd_mem (hz.rd_EX_MEM),
        .we_wb  (hz.regWrite_MEM_WB),
        .rd_wb  (hz.rd_MEM_WB),
        .sel    (fwd_b)
    );

    // MEM_WAIT is transparent once memory is ready: evaluate as the stored state.
    always_comb begin
        freeze    = !hz.memReady;
        eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;
        load_use  = hz.ctrlMemRead_ID_EX && (hz.rt_ID_EX != '0) &&
                    ((hz.usesRs_IF_ID && (hz.rt_ID_EX == hz.rs_IF_ID)) ||
                     (hz.usesRt_IF_ID && (hz.rt_ID_EX == hz.rt_IF_ID)));
        hilo_haz  = hz.usesHiLo_IF_ID && ((md_cnt_q != '0) || hz.mdStart);
        stall     = (eff_state == LOAD_WAIT) || load_use || hilo_haz;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ret_q    <= IDLE;
            ld_cnt_q <= '0;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            ld_cnt_q <= ld_cnt_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        ld_cnt_d = ld_cnt_q;
        md_cnt_d = md_cnt_q;
        if (freeze) begin
            state_d = MEM_WAIT;
            ret_d   = eff_state;
        end else begin
            state_d = eff_state;
            ret_d   = IDLE;
            case (eff_state)
                IDLE: begin
                    if (load_use && (LOAD_DELAY > 1)) begin
                        state_d  = LOAD_WAIT;
                        ld_cnt_d = LD_CNT_W'(LOAD_DELAY - 1);
                    end
                end
                LOAD_WAIT: begin
                    ld_cnt_d = ld_cnt_q - LD_CNT_W'(1);
                    if (ld_cnt_q == LD_CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (hz.mdStart) begin
                md_cnt_d = MD_CNT_W'(MD_LATENCY);
            end else if (md_cnt_q != '0) begin
                md_cnt_d = md_cnt_q - MD_CNT_W'(1);
            end
        end
    end

    always_comb begin
        hz.stallPC    = 1'b0;
        hz.stallIF_ID = 1'b0;
        hz.flushIF_ID = 1'b0;
        hz.flushID_EX = 1'b0;
        hz.freezeAll  = 1'b0;
        hz.fwdA       = FWD_REG;
        hz.fwdB       = FWD_REG;
        hz.mdBusy     = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                hz.freezeAll  = 1'b1;
                hz.stallPC    = 1'b1;
                hz.stallIF_ID = 1'b1;
            end else if (stall) begin
                hz.stallPC    = 1'b1;
                hz.stallIF_ID = 1'b1;
                hz.flushID_EX = 1'b1;
            end else begin
                hz.flushIF_ID = hz.branchTaken_ID;
            end
            hz.fwdA   = fwd_a;
            hz.fwdB   = fwd_b;
            hz.mdBusy = (md_cnt_q != '0);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_DELAY 1/3) share one stimulus.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld, u_rs, u_rt, u_hl, md_start, we_mem, we_wb, br, mem_rdy;
    logic [4:0] rt_ex, rs_id, rt_id, rs_ex, rd_mem, rd_wb;
    int         passed = 0;
    int         total  = 0;

    localparam logic [4:0] C_NONE   = 5'b00000;
    localparam logic [4:0] C_STALL  = 5'b11010;
    localparam logic [4:0] C_FREEZE = 5'b11001;
    localparam logic [4:0] C_FLUSH  = 5'b00100;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5)) if_a ();
    hazard_ctrl_if #(.REG_W(5)) if_b ();

    assign if_a.ctrlMemRead_ID_EX = ld;       assign if_b.ctrlMemRead_ID_EX = ld;
    assign if_a.rt_ID_EX          = rt_ex;    assign if_b.rt_ID_EX          = rt_ex;
    assign if_a.rs_IF_ID          = rs_id;    assign if_b.rs_IF_ID          = rs_id;
    assign if_a.rt_IF_ID          = rt_id;    assign if_b.rt_IF_ID          = rt_id;
    assign if_a.usesRs_IF_ID      = u_rs;     assign if_b.usesRs_IF_ID      = u_rs;
    assign if_a.usesRt_IF_ID      = u_rt;     assign if_b.usesRt_IF_ID      = u_rt;
    assign if_a.usesHiLo_IF_ID    = u_hl;     assign if_b.usesHiLo_IF_ID    = u_hl;
    assign if_a.mdStart           = md_start; assign if_b.mdStart           = md_start;
    assign if_a.rs_ID_EX          = rs_ex;    assign if_b.rs_ID_EX          = rs_ex;
    assign if_a.regWrite_EX_MEM   = we_mem;   assign if_b.regWrite_EX_MEM   = we_mem;
    assign if_a.regWrite_MEM_WB   = we_wb;    assign if_b.regWrite_MEM_WB   = we_wb;
    assign if_a.rd_EX_MEM         = rd_mem;   assign if_b.rd_EX_MEM         = rd_mem;
    assign if_a.rd_MEM_WB         = rd_wb;    assign if_b.rd_MEM_WB         = rd_wb;
    assign if_a.branchTaken_ID    = br;       assign if_b.branchTaken_ID    = br;
    assign if_a.memReady          = mem_rdy;  assign if_b.memReady          = mem_rdy;

    hazard_ctrl #(.REG_W(5), .LOAD_DELAY(1), .MD_LATENCY(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (if_a.slave)
    );

    hazard_ctrl #(.REG_W(5), .LOAD_DELAY(3), .MD_LATENCY(16)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (if_b.slave)
    );

    logic [4:0] ctl_a, ctl_b;
    assign ctl_a = {if_a.stallPC, if_a.stallIF_ID, if_a.flushIF_ID, if_a.flushID_EX, if_a.freezeAll};
    assign ctl_b = {if_b.stallPC, if_b.stallIF_ID, if_b.flushIF_ID, if_b.flushID_EX, if_b.freezeAll};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld = 0; u_rs = 0; u_rt = 0; u_hl = 0; md_start = 0;
        we_mem = 0; we_wb = 0; br = 0; mem_rdy = 1;
        rt_ex = '0; rs_id = '0; rt_id = '0; rs_ex = '0; rd_mem = '0; rd_wb = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        ld = 1; rt_ex = 5; rs_id = 5; u_rs = 1; br = 1; u_hl = 1; md_start = 1;
        rs_ex = 7; rd_mem = 7; we_mem = 1;
        #2;
        if (ctl_a !== C_NONE) $display("FAIL reset_ctl_a: got %b expected %b", ctl_a, C_NONE); else passed++;
        total++;
        if (if_a.fwdA !== 2'b00) $display("FAIL reset_fwdA: got %b expected 00", if_a.fwdA); else passed++;
        total++;
        if (if_a.mdBusy !== 1'b0) $display("FAIL reset_mdBusy: got %b expected 0", if_a.mdBusy); else passed++;
        total++;
        cyc();
        idle_inputs();
        rst_n = 1;
        #2;
        if (ctl_b !== C_NONE || if_b.mdBusy !== 1'b0)
            $display("FAIL post_reset_b: ctl=%b busy=%b expected %b busy=0", ctl_b, if_b.mdBusy, C_NONE);
        else passed++;
        total++;
    endtask

    task automatic test_load1();
        do_reset();
        ld = 1; rt_ex = 5; rs_id = 5; u_rs = 1;
        #2;
        if (ctl_a !== C_STALL) $display("FAIL load1_c0: got %b expected %b", ctl_a, C_STALL); else passed++;
        total++;
        cyc();
        ld = 0;
        #2;
        if (ctl_a !== C_NONE) $display("FAIL load1_c1: got %b expected %b", ctl_a, C_NONE); else passed++;
        total++;
        ld = 1; u_rs = 0;
        #2;
        if (ctl_a !== C_NONE) $display("FAIL load1_unused_rs: got %b expected %b", ctl_a, C_NONE); else passed++;
        total++;
        u_rt = 1; rt_id = 5;
        #2;
        if (ctl_a !== C_STALL) $display("FAIL load1_rt_match: got %b expected %b", ctl_a, C_STALL); else passed++;
        total++;
        cyc();
    endtask

    task automatic test_load3();
        do_reset();
        ld = 1; rt_ex = 5; rs_id = 5; u_rs = 1;
        #2;
        if (ctl_b !== C_STALL) $display("FAIL load3_c0: got %b expected %b", ctl_b, C_STALL); else passed++;
        total++;
        cyc();
        ld = 0;
        for (int i = 1; i < 3; i++) begin
            #2;
            if (ctl_b !== C_STALL) $display("FAIL load3_c%0d: got %b expected %b", i, ctl_b, C_STALL); else passed++;
            total++;
            cyc();
        end
        #2;
        if (ctl_b !== C_NONE) $display("FAIL load3_c3: got %b expected %b", ctl_b, C_NONE); else passed++;
        total++;
        ld = 1; rt_ex = 0; rs_id = 0; rt_id = 0; u_rt = 1;
        #2;
        if (ctl_b !== C_NONE) $display("FAIL load3_r0: got %b expected %b", ctl_b, C_NONE); else passed++;
        total++;
        cyc();
    endtask

    task automatic test_muldiv();
        do_reset();
        md_start = 1;
        #2;
        if (if_a.mdBusy !== 1'b0) $display("FAIL md_c0_busy: got %b expected 0", if_a.mdBusy); else passed++;
        total++;
        cyc();
        md_start = 0; u_hl = 1;
        for (int i = 1; i <= 4; i++) begin
            #2;
            if (ctl_a !== C_STALL || if_a.mdBusy !== 1'b1)
                $display("FAIL md_c%0d: ctl=%b busy=%b expected %b busy=1", i, ctl_a, if_a.mdBusy, C_STALL);
            else passed++;
            total++;
            cyc();
        end
        #2;
        if (ctl_a !== C_NONE || if_a.mdBusy !== 1'b0)
            $display("FAIL md_c5: ctl=%b busy=%b expected %b busy=0", ctl_a, if_a.mdBusy, C_NONE);
        else passed++;
        total++;
        md_start = 1;
        #2;
        if (ctl_a !== C_STALL) $display("FAIL md_start_hilo: got %b expected %b", ctl_a, C_STALL); else passed++;
        total++;
        cyc();
    endtask

    task automatic test_freeze();
        do_reset();
        ld = 1; rt_ex = 5; rs_id = 5; u_rs = 1;
        #2;
        if (ctl_b !== C_STALL) $display("FAIL frz_c0: got %b expected %b", ctl_b, C_STALL); else passed++;
        total++;
        cyc();
        ld = 0; mem_rdy = 0; br = 1;
        for (int i = 1; i <= 2; i++) begin
            #2;
            if (ctl_b !== C_FREEZE) $display("FAIL frz_c%0d: got %b expected %b", i, ctl_b, C_FREEZE); else passed++;
            total++;
            cyc();
        end
        mem_rdy = 1; br = 0;
        for (int i = 3; i <= 4; i++) begin
            #2;
            if (ctl_b !== C_STALL) $display("FAIL frz_c%0d: got %b expected %b", i, ctl_b, C_STALL); else passed++;
            total++;
            cyc();
        end
        #2;
        if (ctl_b !== C_NONE) $display("FAIL frz_c5: got %b expected %b", ctl_b, C_NONE); else passed++;
        total++;
    endtask

    task automatic test_fwd_branch();
        do_reset();
        rs_ex = 7; rt_ex = 7; rd_mem = 7; rd_wb = 7; we_mem = 1; we_wb = 1;
        #2;
        if (if_a.fwdA !== 2'b10 || if_a.fwdB !== 2'b10)
            $display("FAIL fwd_both: A=%b B=%b expected 10 10", if_a.fwdA, if_a.fwdB);
        else passed++;
        total++;
        we_mem = 0;
        #2;
        if (if_a.fwdA !== 2'b01) $display("FAIL fwd_wb: got %b expected 01", if_a.fwdA); else passed++;
        total++;
        rd_wb = 3;
        #2;
        if (if_a.fwdA !== 2'b00) $display("FAIL fwd_none: got %b expected 00", if_a.fwdA); else passed++;
        total++;
        rs_ex = 0; rt_ex = 0; rd_mem = 0; rd_wb = 0; we_mem = 1; we_wb = 1;
        #2;
        if (if_a.fwdA !== 2'b00 || if_a.fwdB !== 2'b00)
            $display("FAIL fwd_r0: A=%b B=%b expected 00 00", if_a.fwdA, if_a.fwdB);
        else passed++;
        total++;
        idle_inputs();
        br = 1;
        #2;
        if (ctl_a !== C_FLUSH) $display("FAIL br_flush: got %b expected %b", ctl_a, C_FLUSH); else passed++;
        total++;
        ld = 1; rt_ex = 5; rs_id = 5; u_rs = 1;
        #2;
        if (ctl_a !== C_STALL) $display("FAIL br_with_stall: got %b expected %b", ctl_a, C_STALL); else passed++;
        total++;
        cyc();
        idle_inputs();
    endtask

    task automatic test_reset_abort();
        do_reset();
        md_start = 1;
        cyc();
        md_start = 0;
        repeat (6) cyc();
        #2;
        if (if_b.mdBusy !== 1'b1) $display("FAIL md_cnt10_busy: got %b expected 1", if_b.mdBusy); else passed++;
        total++;
        rst_n = 0;
        #2;
        if (if_b.mdBusy !== 1'b0) $display("FAIL md_rst_cycle: got %b expected 0", if_b.mdBusy); else passed++;
        total++;
        cyc();
        rst_n = 1; u_hl = 1;
        #2;
        if (ctl_b !== C_NONE || if_b.mdBusy !== 1'b0)
            $display("FAIL md_after_rst: ctl=%b busy=%b expected %b busy=0", ctl_b, if_b.mdBusy, C_NONE);
        else passed++;
        total++;
        idle_inputs();
        ld = 1; rt_ex = 9; rs_id = 9; u_rs = 1;
        cyc();
        ld = 0; rst_n = 0;
        cyc();
        rst_n = 1;
        #2;
        if (ctl_b !== C_NONE) $display("FAIL ld_after_rst: got %b expected %b", ctl_b, C_NONE); else passed++;
        total++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        cyc();
        test_reset();
        test_load1();
        test_load3();
        test_muldiv();
        test_freeze();
        test_fwd_branch();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
